// File: rtl/sha1_pkg.sv
// Shared SHA-1 constants, padder state encoding and the padding-marker helper.
package sha1_pkg;

  localparam int unsigned SHA1_BLOCK_W     = 512;
  localparam int unsigned SHA1_WORD_W      = 32;
  localparam int unsigned SHA1_LEN_FIELD_W = 64;
  localparam int unsigned SHA1_BLOCK_BYTES = SHA1_BLOCK_W / 8;

  typedef enum logic {
    FILL = 1'b0,
    SEND = 1'b1
  } pad_state_e;

  // Place the 0x80 marker at byte 'used' and zero every later byte; used=64 leaves the block intact.
  function automatic logic [SHA1_BLOCK_W-1:0] pad_insert(input logic [SHA1_BLOCK_W-1:0] block,
                                                         input logic [6:0]              used);
    logic [SHA1_BLOCK_W-1:0] b;
    b = block;
    for (int unsigned i = 0; i < SHA1_BLOCK_BYTES; i++) begin
      if (7'(i) == used) begin
        b[8*(SHA1_BLOCK_BYTES-1-i) +: 8] = 8'h80;
      end else if (7'(i) > used) begin
        b[8*(SHA1_BLOCK_BYTES-1-i) +: 8] = 8'h00;
      end
    end
    return b;
  endfunction

endpackage

// File: rtl/sha1_padder.sv
// Packs a 32-bit byte stream into FIPS 180-4 padded 512-bit blocks for the SHA-1 core.
module sha1_padder
  import sha1_pkg::*;
#(
  parameter int unsigned LEN_W = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    o_tready,
  input  logic                    i_tvalid,
  input  logic [31:0]             i_tdata,
  input  logic [3:0]              i_tkeep,
  input  logic                    i_tlast,
  input  logic                    i_tready_out,
  output logic                    o_tvalid_out,
  output logic [SHA1_BLOCK_W-1:0] o_tdata_out,
  output logic [63:0]             o_tkeep_out,
  output logic                    o_tlast_out
);

  localparam int unsigned CNT_W = LEN_W - 3;

  pad_state_e              state, state_n;
  logic [3:0]              widx, widx_n;
  logic [CNT_W-1:0]        cnt, cnt_n, cnt_add;
  logic                    pend, pend_n;
  logic                    pad80, pad80_n;
  logic                    last_n;
  logic                    tready_n, tvalid_n;
  logic [SHA1_BLOCK_W-1:0] blk_n;
  logic [2:0]              nbytes;
  logic [6:0]              used;
  logic [8:0]              wlsb;

  // Byte count to big-endian bit-length field, zero-extended to 64 bits.
  function automatic logic [SHA1_LEN_FIELD_W-1:0] len_field(input logic [CNT_W-1:0] c);
    return SHA1_LEN_FIELD_W'({c, 3'b000});
  endfunction

  assign o_tkeep_out = '1;

  always_comb begin
    state_n = state;
    widx_n  = widx;
    cnt_n   = cnt;
    pend_n  = pend;
    pad80_n = pad80;
    last_n  = o_tlast_out;
    blk_n   = o_tdata_out;

    // Non-last beats always carry four bytes whatever tkeep says.
    nbytes  = i_tlast ? 3'($countones(i_tkeep)) : 3'd4;
    used    = 7'({widx, 2'b00}) + 7'(nbytes);
    cnt_add = cnt + CNT_W'(nbytes);
    wlsb    = {~widx, 5'b00000};

    case (state)
      FILL: begin
        if (i_tvalid && o_tready) begin
          blk_n[wlsb +: SHA1_WORD_W] = i_tdata;
          cnt_n  = cnt_add;
          widx_n = widx + 4'd1;
          if (i_tlast) begin
            blk_n   = pad_insert(blk_n, used);
            state_n = SEND;
            if (used <= 7'd55) begin
              blk_n[SHA1_LEN_FIELD_W-1:0] = len_field(cnt_add);
              last_n = 1'b1;
            end else begin
              // Length does not fit: a trailing block carries it (and the marker when used=64).
              last_n  = 1'b0;
              pend_n  = 1'b1;
              pad80_n = (used == 7'd64);
            end
          end else if (widx == 4'd15) begin
            state_n = SEND;
            last_n  = 1'b0;
          end
        end
      end
      SEND: begin
        if (i_tready_out) begin
          if (pend) begin
            blk_n = '0;
            blk_n[SHA1_BLOCK_W-1 -: 8]  = pad80 ? 8'h80 : 8'h00;
            blk_n[SHA1_LEN_FIELD_W-1:0] = len_field(cnt);
            last_n  = 1'b1;
            pend_n  = 1'b0;
            pad80_n = 1'b0;
          end else begin
            state_n = FILL;
            widx_n  = 4'd0;
            blk_n   = '0;
            last_n  = 1'b0;
            if (o_tlast_out) begin
              cnt_n = '0;
            end
          end
        end
      end
      default: state_n = FILL;
    endcase

    tready_n = (state_n == FILL);
    tvalid_n = (state_n == SEND);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= FILL;
      widx         <= 4'd0;
      cnt          <= '0;
      pend         <= 1'b0;
      pad80        <= 1'b0;
      o_tready     <= 1'b0;
      o_tvalid_out <= 1'b0;
      o_tlast_out  <= 1'b0;
      o_tdata_out  <= '0;
    end else begin
      state        <= state_n;
      widx         <= widx_n;
      cnt          <= cnt_n;
      pend         <= pend_n;
      pad80        <= pad80_n;
      o_tready     <= tready_n;
      o_tvalid_out <= tvalid_n;
      o_tlast_out  <= last_n;
      o_tdata_out  <= blk_n;
    end
  end

endmodule

// File: tb/tb_sha1_padder.sv
// Randomized bench for sha1_padder against a byte-level FIPS 180-4 padding model.
module tb_sha1_padder;

  typedef logic [7:0] byte_q_t[$];
  typedef logic [511:0] blk_q_t[$];
  typedef logic bit_q_t[$];

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         o_tready;
  logic         i_tvalid = 1'b0;
  logic [31:0]  i_tdata = '0;
  logic [3:0]   i_tkeep = '0;
  logic         i_tlast = 1'b0;
  logic         i_tready_out = 1'b0;
  logic         o_tvalid_out;
  logic [511:0] o_tdata_out;
  logic [63:0]  o_tkeep_out;
  logic         o_tlast_out;

  sha1_padder #(.LEN_W(64)) dut (
    .clk          (clk),
    .reset        (reset),
    .o_tready     (o_tready),
    .i_tvalid     (i_tvalid),
    .i_tdata      (i_tdata),
    .i_tkeep      (i_tkeep),
    .i_tlast      (i_tlast),
    .i_tready_out (i_tready_out),
    .o_tvalid_out (o_tvalid_out),
    .o_tdata_out  (o_tdata_out),
    .o_tkeep_out  (o_tkeep_out),
    .o_tlast_out  (o_tlast_out)
  );

  always #5 clk = ~clk;

  localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
  localparam logic [511:0] B56_TAIL  = {480'h0, 32'h000001C0};
  localparam logic [511:0] B64_TAIL  = {32'h80000000, 448'h0, 32'h00000200};

  int           n_checks = 0;
  int           n_pass = 0;
  blk_q_t       exp_blk;
  bit_q_t       exp_last;
  logic         hold_ready = 1'b0;
  int           hs_count = 0;
  logic [511:0] rx_blk = '0;
  logic         rx_last = 1'b0;
  logic         prev_pending = 1'b0;
  logic [511:0] prev_data = '0;
  logic         prev_last = 1'b0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Padding straight from the byte-level rules: msg, 0x80, zeros to 56 mod 64, 64-bit bit length.
  function automatic void model(input byte_q_t msg, output blk_q_t blks, output bit_q_t lasts);
    byte_q_t p;
    logic [63:0] bits;
    int nblk;
    p = msg;
    bits = 64'(msg.size()) * 64'd8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
    blks = {};
    lasts = {};
    nblk = p.size() / 64;
    for (int k = 0; k < nblk; k++) begin
      logic [511:0] b;
      b = '0;
      for (int i = 0; i < 64; i++) b[8*(63-i) +: 8] = p[64*k + i];
      blks.push_back(b);
      lasts.push_back(k == nblk - 1);
    end
  endfunction

  always @(posedge clk) begin
    #1;
    i_tready_out = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Output monitor: stability while stalled, and every handshake against the model queue.
  always @(negedge clk) begin
    if (reset) begin
      prev_pending = 1'b0;
    end else begin
      if (prev_pending) begin
        chk("valid_held", 512'(o_tvalid_out), 512'(1));
        chk("data_stable", o_tdata_out, prev_data);
        chk("last_stable", 512'(o_tlast_out), 512'(prev_last));
      end
      if (o_tvalid_out) begin
        chk("tready_low_in_send", 512'(o_tready), 512'(0));
        chk("tkeep_ones", 512'(o_tkeep_out), 512'(64'hFFFF_FFFF_FFFF_FFFF));
        if (i_tready_out) begin
          chk("block_expected", 512'(exp_blk.size() > 0), 512'(1));
          if (exp_blk.size() > 0) begin
            logic [511:0] eb;
            logic el;
            eb = exp_blk.pop_front();
            el = exp_last.pop_front();
            chk("block_data", o_tdata_out, eb);
            chk("block_last", 512'(o_tlast_out), 512'(el));
          end
          rx_blk = o_tdata_out;
          rx_last = o_tlast_out;
          hs_count++;
        end
      end
      prev_pending = o_tvalid_out && !i_tready_out;
      prev_data = o_tdata_out;
      prev_last = o_tlast_out;
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    int w;
    i_tdata = d;
    i_tkeep = k;
    i_tlast = l;
    i_tvalid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!o_tready && w < 3000) begin
      @(negedge clk);
      w++;
    end
    chk("beat_accept", 512'(o_tready), 512'(1));
    @(posedge clk);
    #1;
    i_tvalid = 1'b0;
    if (l) chk("valid_latency", 512'(o_tvalid_out), 512'(1));
  endtask

  task automatic send_msg(input byte_q_t msg, input bit expect_it);
    int n, nb, rem;
    bit tail;
    if (expect_it) begin
      blk_q_t b;
      bit_q_t l;
      model(msg, b, l);
      foreach (b[i]) begin
        exp_blk.push_back(b[i]);
        exp_last.push_back(l[i]);
      end
    end
    n = msg.size();
    rem = n % 4;
    nb = n / 4 + ((rem != 0) ? 1 : 0);
    tail = (nb == 0) || (rem == 0 && $urandom_range(0, 1) == 1);
    for (int b = 0; b < nb; b++) begin
      logic [31:0] w;
      logic [3:0] kp;
      bit is_last;
      for (int i = 0; i < 4; i++) begin
        int idx;
        idx = 4*b + i;
        w[8*(3-i) +: 8] = (idx < n) ? msg[idx] : 8'($urandom);
      end
      is_last = !tail && (b == nb - 1);
      if (is_last) begin
        kp = 4'hF;
        kp = kp << (4 - (n - 4*b));
      end else begin
        kp = 4'($urandom);
      end
      if ($urandom_range(0, 3) == 0) cycles($urandom_range(1, 3));
      drive_beat(w, kp, is_last);
    end
    if (tail) drive_beat($urandom, 4'h0, 1'b1);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_blk.size() != 0 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    chk("drain", 512'(exp_blk.size()), 512'(0));
    cycles(2);
  endtask

  function automatic byte_q_t rand_msg(input int len);
    byte_q_t m;
    m = {};
    for (int i = 0; i < len; i++) m.push_back(8'($urandom));
    return m;
  endfunction

  initial begin
    byte_q_t m;
    blk_q_t mb;
    bit_q_t ml;
    int hs0;

    cycles(3);
    @(negedge clk);
    chk("reset_tready", 512'(o_tready), 512'(0));
    chk("reset_tvalid", 512'(o_tvalid_out), 512'(0));
    chk("reset_tlast", 512'(o_tlast_out), 512'(0));
    chk("reset_tdata", o_tdata_out, 512'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("tready_after_reset", 512'(o_tready), 512'(1));

    // Pin the model with hand-computed blocks.
    m = {8'h61, 8'h62, 8'h63};
    model(m, mb, ml);
    chk("model_abc_n", 512'(mb.size()), 512'(1));
    chk("model_abc_blk", mb[0], ABC_BLK);
    model(rand_msg(0), mb, ml);
    chk("model_empty_blk", mb[0], EMPTY_BLK);
    model(rand_msg(56), mb, ml);
    chk("model_56_w14", 512'(mb[0][63:32]), 512'(32'h80000000));
    chk("model_56_w15", 512'(mb[0][31:0]), 512'(0));
    chk("model_56_tail", mb[1], B56_TAIL);
    model(rand_msg(64), mb, ml);
    chk("model_64_tail", mb[1], B64_TAIL);
    chk("model_64_lasts", 512'({ml[0], ml[1]}), 512'(2'b01));

    // Directed messages, last block checked against literals.
    send_msg(m, 1'b1);
    drain();
    chk("dut_abc", rx_blk, ABC_BLK);
    chk("dut_abc_last", 512'(rx_last), 512'(1));
    send_msg(rand_msg(0), 1'b1);
    drain();
    chk("dut_empty", rx_blk, EMPTY_BLK);
    send_msg(rand_msg(56), 1'b1);
    drain();
    chk("dut_56_tail", rx_blk, B56_TAIL);
    send_msg(rand_msg(64), 1'b1);
    drain();
    chk("dut_64_tail", rx_blk, B64_TAIL);
    chk("dut_64_last", 512'(rx_last), 512'(1));

    // Backpressure: five stalled cycles, then exactly one transfer.
    hold_ready = 1'b1;
    cycles(1);
    send_msg(rand_msg(5), 1'b1);
    begin
      logic [511:0] d0;
      logic l0;
      d0 = o_tdata_out;
      l0 = o_tlast_out;
      hs0 = hs_count;
      repeat (5) begin
        @(negedge clk);
        chk("bp_data", o_tdata_out, d0);
        chk("bp_last", 512'(o_tlast_out), 512'(l0));
        chk("bp_tready", 512'(o_tready), 512'(0));
      end
    end
    hold_ready = 1'b0;
    drain();
    cycles(4);
    chk("bp_one_block", 512'(hs_count - hs0), 512'(1));

    // Reset while a block is being offered.
    hold_ready = 1'b1;
    cycles(1);
    send_msg(rand_msg(9), 1'b0);
    cycles(2);
    reset = 1'b1;
    #1;
    chk("reset_drops_valid", 512'(o_tvalid_out), 512'(0));
    chk("reset_drops_tready", 512'(o_tready), 512'(0));
    hold_ready = 1'b0;
    cycles(2);
    reset = 1'b0;
    cycles(1);

    // Reset after seven beats of a message, then "abc".
    for (int i = 0; i < 7; i++) drive_beat($urandom, 4'hF, 1'b0);
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
    hs0 = hs_count;
    send_msg(m, 1'b1);
    drain();
    chk("post_reset_abc", rx_blk, ABC_BLK);
    chk("post_reset_count", 512'(hs_count - hs0), 512'(1));

    // Random traffic, weighted toward the block-boundary lengths.
    for (int t = 0; t < 40; t++) begin
      int len;
      if ($urandom_range(0, 3) == 0) len = 52 + $urandom_range(0, 16);
      else len = $urandom_range(0, 140);
      send_msg(rand_msg(len), 1'b1);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
